// File: rtl/debounce_scheduler_if.sv
// debounce_scheduler_if: button, delay and event signals shared between the scheduler and its user.
interface debounce_scheduler_if #(
   parameter int N_BTN = 4,
   parameter int CNT_W = 32
);
   localparam int IDX_W = $clog2(N_BTN);
   logic [N_BTN-1:0] in_btn;
   logic [CNT_W-1:0] delay;
   logic [N_BTN-1:0] pulse;
   logic             busy;
   logic [IDX_W-1:0] active_idx;
   logic [N_BTN-1:0] stuck;
   modport master (output in_btn, delay, input pulse, busy, active_idx, stuck);
   modport slave (input in_btn, delay, output pulse, busy, active_idx, stuck);
endinterface

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: one saturating hold counter shared round-robin across N_BTN active-low buttons.
// Define STUCK_TIMEOUT_EN to flag and mask buttons held STUCK_LIMIT cycles past the delay.
module debounce_scheduler #(
   parameter int N_BTN       = 4,
   parameter int CNT_W       = 32,
   parameter int STUCK_LIMIT = 50000000
) (
   input logic                 clock_i,
   input logic                 reset_n_i,
   debounce_scheduler_if.slave bus
);
   localparam int IDX_W = $clog2(N_BTN);
   typedef enum logic {SCAN, HOLD} state_t;
   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d, grant_idx, cand_idx, next_idx;
   logic [CNT_W-1:0] count_q, count_d, dly_q, dly_d;
   logic [N_BTN-1:0] pulse_q, pulse_d, cand;
   logic             found;
   if (N_BTN < 2 || STUCK_LIMIT < 1) begin : g_param_chk
      $error("debounce_scheduler: N_BTN must be >= 2 and STUCK_LIMIT >= 1");
   end
`ifdef STUCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] OC_LAST = CNT_W'(STUCK_LIMIT - 1);
   logic [N_BTN-1:0] mask_q, mask_d, stuck_q, stuck_d;
   logic [CNT_W-1:0] oc_q, oc_d;
   assign cand      = ~bus.in_btn & ~mask_q;
   assign bus.stuck = stuck_q;
`else
   assign cand      = ~bus.in_btn;
   assign bus.stuck = '0;
`endif
   assign next_idx       = (idx_q == IDX_W'(N_BTN - 1)) ? '0 : idx_q + IDX_W'(1);
   assign bus.pulse      = pulse_q;
   assign bus.busy       = (state_q == HOLD);
   assign bus.active_idx = idx_q;
   // round-robin search: first pressed, unmasked button at or after ptr
   always_comb begin
      found     = 1'b0;
      grant_idx = ptr_q;
      cand_idx  = ptr_q;
      for (int k = 0; k < N_BTN; k++) begin
         cand_idx = IDX_W'((int'(ptr_q) + k) % N_BTN);
         if (!found && cand[cand_idx]) begin
            found     = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end
   // scheduler FSM: grant in SCAN, count the hold and judge the release in HOLD
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      count_d = count_q;
      dly_d   = dly_q;
      pulse_d = '0;
`ifdef STUCK_TIMEOUT_EN
      mask_d  = mask_q & ~bus.in_btn;
      stuck_d = stuck_q & ~bus.in_btn;
      oc_d    = oc_q;
`endif
      if (state_q == SCAN) begin
         if (found) begin
            idx_d   = grant_idx;
            dly_d   = bus.delay;
            count_d = '0;
            state_d = HOLD;
`ifdef STUCK_TIMEOUT_EN
            oc_d    = '0;
`endif
         end
      end else if (bus.in_btn[idx_q]) begin
         pulse_d[idx_q] = (count_q == dly_q);
         count_d        = '0;
         ptr_d          = next_idx;
         state_d        = SCAN;
      end else if (count_q < dly_q) begin
         count_d = count_q + CNT_W'(1);
`ifdef STUCK_TIMEOUT_EN
      end else if (oc_q == OC_LAST) begin
         stuck_d[idx_q] = 1'b1;
         mask_d[idx_q]  = 1'b1;
         count_d        = '0;
         ptr_d          = next_idx;
         state_d        = SCAN;
      end else begin
         oc_d = oc_q + CNT_W'(1);
`endif
      end
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q <= SCAN;
         ptr_q   <= '0;
         idx_q   <= '0;
         count_q <= '0;
         dly_q   <= '0;
         pulse_q <= '0;
`ifdef STUCK_TIMEOUT_EN
         mask_q  <= '0;
         stuck_q <= '0;
         oc_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         dly_q   <= dly_d;
         pulse_q <= pulse_d;
`ifdef STUCK_TIMEOUT_EN
         mask_q  <= mask_d;
         stuck_q <= stuck_d;
         oc_q    <= oc_d;
`endif
      end
   end
endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Shares one debounce counter engine across N_BTN active-low push-buttons feeding the ALU operand/operation entry logic.
- A round-robin scheduler grants the counter to one pressed button at a time.
- The granted button is counted while held. On release, a single-cycle pulse is issued on that button's output only if the hold reached the configured delay.
- Replaces per-button debounce counters with one counter plus arbitration.

Parameters:
- N_BTN, 4, number of button inputs (>=2).
- CNT_W, 32, width of the delay and hold counter.
- STUCK_LIMIT, 50000000, extra cycles past delay before a hold is declared stuck (used only with STUCK_TIMEOUT_EN).
- Derived localparam IDX_W = $clog2(N_BTN).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_btn  in  N_BTN  raw button levels, already synchronised; 0 = pressed, 1 = released.
- delay  in  CNT_W  required hold length in cycles; sampled at grant.
- pulse  out  N_BTN  one-hot, single-cycle debounced press events.
- busy  out  1  high while a button holds the counter (HOLD state).
- active_idx  out  IDX_W  index of the granted button; holds last grant when idle.
- stuck  out  N_BTN  stuck flags (STUCK_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=SCAN, ptr=0, count=0, delay_q=0, active_idx=0.
  - pulse=0, busy=0, stuck=0, mask=0.
  - Reset mid-HOLD aborts the hold with no pulse.
- States: SCAN, HOLD.
- SCAN:
  - Search candidates with in_btn[i]==0 and mask[i]==0.
  - Order is ptr, ptr+1, ... wrapping modulo N_BTN; the first match is granted.
  - On grant: active_idx<=i, delay_q<=delay, count<=0, busy<=1, state<=HOLD.
  - No candidate: remain in SCAN, ptr unchanged.
- HOLD, button idx=active_idx:
  - While in_btn[idx]==0: count<=count+1 if count<delay_q, otherwise saturate at delay_q.
  - On in_btn[idx]==1 (release): pulse[idx]<=1 iff count==delay_q.
  - Also on release: count<=0, busy<=0, ptr<=(idx+1) mod N_BTN, state<=SCAN.
- Timing:
  - A release sampled at edge t drives pulse high for exactly the cycle after t.
  - SCAN may grant in that same cycle, so HOLD re-entry occurs at edge t+1.
  - Minimum hold for a pulse is delay_q+1 sampled-low cycles after the grant edge.
- Boundary conditions:
  - delay==0: any grant followed by a release pulses.
  - A delay change during HOLD has no effect; delay_q is used.
  - Presses on other buttons during HOLD are ignored; they are not queued.
  - A button still held when later scanned is granted fresh with count from 0.
  - A press released before being granted is lost with no pulse.
  - Only one pulse bit is ever high in any cycle.
  - The counter never wraps, because it saturates.

Optional Feature:
- Macro: STUCK_TIMEOUT_EN.
- Defined:
  - Separate over-counter oc increments once count==delay_q while the button is still held.
  - When oc reaches STUCK_LIMIT: stuck[idx]<=1 and mask[idx]<=1; HOLD is abandoned with no pulse; ptr<=idx+1; state<=SCAN.
  - mask[i] clears when in_btn[i]==1 is sampled. stuck[i] clears at the same time.
  - A masked button is never granted.
  - Reset clears oc, mask and stuck.
- Undefined:
  - No over-counter and no masking; stuck output is constant 0.
  - A held button occupies the counter indefinitely.

Test Plan:
- Bounce rejection: delay=5; hold in_btn[1]=0 for 3 cycles then release -> no pulse; busy 1 then 0; active_idx=1.
- Valid press: delay=5; in_btn[2]=0 for 10 cycles then release -> pulse=4'b0100 for exactly one cycle, the cycle after release is sampled.
- Round-robin fairness: in_btn[0] and in_btn[3] held together with delay=2 -> button 0 granted first; after button 0 releases, button 3 is granted next (ptr=1 wrap search); pulse[0] then pulse[3].
- delay=0 edge case: one-cycle press on button 0 -> pulse[0]=1 once. Change delay to 100 mid-HOLD on another press of 5 cycles with delay_q=3 -> pulse still issued.
- Reset mid-operation: reset_n=0 for one cycle during HOLD with count=4 of delay=5, button held and then released -> no pulse; after reset, busy=0, active_idx=0, re-grant on the next SCAN.
- STUCK_TIMEOUT_EN with STUCK_LIMIT=8, delay=2: hold button 1 for 20 cycles -> stuck[1]=1 after 2+8 held cycles, no pulse, button 1 not re-granted; release -> stuck[1]=0.
